// File: rtl/bc_ramp.sv
// ---------------------------------------------------------------------------
// bc_ramp -- slew-rate limiter for a signed speed/direction command.
//
// A target command from upstream is approached by at most STEP per ramp
// tick (one tick every TICK_DIV clocks). Every change of the current command
// is offered once to the downstream PWM stage through a valid/ready
// handshake, and a pending output defers further steps until it is taken.
//
// Build option: define BC_RAMP_DWELL_EN to force direction reversals to ramp
// down to zero and hold there for DWELL_TICKS ticks before ramping up the
// other way. Without it the command crosses zero in ordinary steps.
//
// Parameters
//   STEP         maximum change of the command per tick (1..1024)
//   TICK_DIV     clocks per ramp tick (>= 2)
//   DWELL_TICKS  ticks held at zero on a reversal (>= 1)
//
// Ports
//   CLK100MHZ  in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   in_data    in   [15:0] signed target command
//   in_valid   in   in_data valid
//   in_rdy     out  target accepted (high except during reset)
//   out_data   out  [15:0] signed ramped command
//   out_valid  out  out_data valid, held until out_rdy
//   out_rdy    in   downstream accepts out_data
//   busy       out  command differs from target, or dwelling at zero
// ---------------------------------------------------------------------------
module bc_ramp #(
  parameter int STEP        = 16,
  parameter int TICK_DIV    = 1000,
  parameter int DWELL_TICKS = 4
) (
  input  logic        CLK100MHZ,
  input  logic        rst,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_rdy,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_rdy,
  output logic        busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RAMP  = 2'd1;
  localparam logic [1:0] S_DWELL = 2'd2;

  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;

  localparam logic signed [15:0] STEP_16 = 16'(STEP);
  localparam logic signed [16:0] STEP_17 = 17'(STEP);

  logic [TW-1:0]      tick_cnt;
  logic               tick;
  logic [1:0]         state;
  logic [DW-1:0]      dwell_cnt;
  logic signed [15:0] cur;
  logic signed [15:0] target;
  logic signed [15:0] in_sat;
  logic signed [15:0] goal;
  logic signed [15:0] next_cur;
  logic signed [16:0] diff;
  logic               reversal;
  logic               pending;

  assign tick    = (tick_cnt == TW'(TICK_DIV - 1));
  assign in_rdy  = ~rst;
  assign pending = out_valid & ~out_rdy;

  // -32768 has no positive twin; clamp it so magnitudes stay symmetric.
  assign in_sat = (in_data == 16'h8000) ? 16'sh8001 : $signed(in_data);

`ifdef BC_RAMP_DWELL_EN
  // Opposite non-zero signs: head for zero first, the dwell follows there.
  assign reversal = (cur != 16'sd0) && (target != 16'sd0) && (cur[15] != target[15]);
`else
  assign reversal = 1'b0;
`endif

  assign goal = reversal ? 16'sd0 : target;

  // The distance to the goal can reach 65534, so it is taken at 17 bits;
  // a full step is only taken when it cannot pass the goal, which also
  // keeps cur +/- STEP inside the 16-bit range.
  // NOTE: every always_comb output gets a value on every path (here a default
  // first) so no latch is inferred.
  always_comb begin
    next_cur = goal;
    diff     = {goal[15], goal} - {cur[15], cur};
    if (diff > STEP_17) begin
      next_cur = cur + STEP_16;
    end else if (diff < -STEP_17) begin
      next_cur = cur - STEP_16;
    end
  end

  assign out_data = cur;
  assign busy     = (state == S_DWELL) || (cur != target);

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values; the reset branch is synchronous and has priority.
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      tick_cnt  <= '0;
      state     <= S_IDLE;
      dwell_cnt <= '0;
      cur       <= 16'sd0;
      target    <= 16'sd0;
      out_valid <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);

      if (out_valid && out_rdy) begin
        out_valid <= 1'b0;
      end

      // The step below reads the pre-edge target, so a target arriving on a
      // tick cycle takes effect at the following tick.
      if (in_valid && in_rdy) begin
        target <= in_sat;
      end

      if (state == S_DWELL) begin
        // Target changes do not shorten the dwell; the latest one is used
        // when it ends.
        if (tick) begin
          if (dwell_cnt == DW'(DWELL_TICKS - 1)) begin
            dwell_cnt <= '0;
            state     <= (target == 16'sd0) ? S_IDLE : S_RAMP;
          end else begin
            dwell_cnt <= dwell_cnt + DW'(1);
          end
        end
      end else if (cur == target) begin
        state <= S_IDLE;
      end else begin
        state <= S_RAMP;
        // An untaken output blocks the step; it is retried on the next tick.
        if (tick && !pending) begin
          cur       <= next_cur;
          out_valid <= 1'b1;
          if (next_cur == target) begin
            state <= S_IDLE;
          end else if (reversal && (next_cur == 16'sd0)) begin
            state     <= S_DWELL;
            dwell_cnt <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bc_ramp.sv
// ---------------------------------------------------------------------------
// tb_bc_ramp -- self-checking bench for bc_ramp (STEP=16, TICK_DIV=4,
// DWELL_TICKS=2). A tick-level reference model written with plain integer
// arithmetic predicts out_valid/out_data/busy/in_rdy every cycle; directed
// scenarios additionally check the emitted output sequences against
// hand-derived constants. Honours BC_RAMP_DWELL_EN like the design.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bc_ramp;

  localparam int STEP        = 16;
  localparam int TICK_DIV    = 4;
  localparam int DWELL_TICKS = 2;
`ifdef BC_RAMP_DWELL_EN
  localparam bit DWELL_ON = 1'b1;
`else
  localparam bit DWELL_ON = 1'b0;
`endif

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic [15:0] in_data  = 16'h0000;
  logic        in_valid = 1'b0;
  logic        in_rdy;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_rdy  = 1'b1;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state (integers, tick-level view of the behaviour).
  int m_cnt    = 0;
  int m_target = 0;
  int m_cur    = 0;
  int m_dwell  = 0;
  bit m_ov     = 1'b0;

  bit last_ov = 1'b0;
  int got[$];

  always #5 clk = ~clk;

  bc_ramp #(
    .STEP       (STEP),
    .TICK_DIV   (TICK_DIV),
    .DWELL_TICKS(DWELL_TICKS)
  ) dut (
    .CLK100MHZ(clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_rdy   (in_rdy),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_rdy  (out_rdy),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge of the reference model, using the inputs seen at the edge.
  task automatic model_edge();
    int  goal;
    int  d;
    int  nc;
    bit  tick;
    bit  pend;
    if (rst) begin
      m_cnt = 0; m_target = 0; m_cur = 0; m_dwell = 0; m_ov = 1'b0;
      return;
    end
    tick  = (m_cnt == TICK_DIV - 1);
    pend  = m_ov && !out_rdy;
    m_cnt = tick ? 0 : m_cnt + 1;
    if (m_ov && out_rdy) m_ov = 1'b0;
    if (m_dwell > 0) begin
      if (tick) m_dwell--;
    end else if (tick && !pend && (m_cur != m_target)) begin
      goal = m_target;
      if (DWELL_ON && m_cur != 0 && m_target != 0 && ((m_cur < 0) != (m_target < 0)))
        goal = 0;
      d = goal - m_cur;
      if (d > STEP)       nc = m_cur + STEP;
      else if (d < -STEP) nc = m_cur - STEP;
      else                nc = goal;
      m_cur = nc;
      m_ov  = 1'b1;
      if (DWELL_ON && goal == 0 && m_target != 0 && nc == 0) m_dwell = DWELL_TICKS;
    end
    if (in_valid) m_target = (in_data == 16'h8000) ? -32767 : int'($signed(in_data));
  endtask

  // Advance one clock, update the model, then check the DUT 1 ns later.
  task automatic cyc();
    bit held;
    held = last_ov && !out_rdy;
    @(posedge clk);
    model_edge();
    #1;
    chk("out_valid", out_valid, m_ov);
    chk("out_data", $signed(out_data), m_cur);
    chk("busy", busy, (m_dwell > 0) || (m_cur != m_target));
    chk("in_rdy", in_rdy, !rst);
    if (out_valid && !held) got.push_back(int'($signed(out_data)));
    last_ov = out_valid;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic send(input int v);
    in_data  = 16'(v);
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic wait_got(input int n, input int bound, input string tag);
    int k = 0;
    while (got.size() < n && k < bound) begin
      cyc();
      k++;
    end
    chk({tag, "_timeout"}, got.size() >= n, 1);
  endtask

  function automatic int gv(input int i);
    return (i < got.size()) ? got[i] : -100000;
  endfunction

  initial begin
    int k;
    int v;

    // Reset
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    #1;
    chk("rst_in_rdy", in_rdy, 1);
    chk("rst_out_data", $signed(out_data), 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);

    // Ramp up 0 -> 40
    got.delete();
    send(40);
    run(40);
    chk("up_count", got.size(), 3);
    chk("up_0", gv(0), 16);
    chk("up_1", gv(1), 32);
    chk("up_2", gv(2), 40);
    chk("up_busy", busy, 0);

    // Reversal 40 -> -20
    got.delete();
    send(-20);
    run(60);
    if (DWELL_ON) begin
      chk("rev_count", got.size(), 5);
      chk("rev_0", gv(0), 24);
      chk("rev_1", gv(1), 8);
      chk("rev_2", gv(2), 0);
      chk("rev_3", gv(3), -16);
      chk("rev_4", gv(4), -20);
    end else begin
      chk("rev_count", got.size(), 4);
      chk("rev_0", gv(0), 24);
      chk("rev_1", gv(1), 8);
      chk("rev_2", gv(2), -8);
      chk("rev_3", gv(3), -20);
    end
    chk("rev_busy", busy, 0);

    // Back to zero, then backpressure
    send(0);
    run(30);
    chk("zero_data", $signed(out_data), 0);
    got.delete();
    out_rdy = 1'b0;
    send(40);
    run(40);
    chk("bp_count", got.size(), 1);
    chk("bp_hold_data", $signed(out_data), 16);
    chk("bp_hold_valid", out_valid, 1);
    out_rdy = 1'b1;
    wait_got(2, 4, "bp_next");
    chk("bp_1", gv(1), 32);
    run(20);
    chk("bp_count_end", got.size(), 3);
    chk("bp_2", gv(2), 40);

    // Reset in the middle of a ramp
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    got.delete();
    send(1000);
    wait_got(3, 40, "mid_ramp");
    chk("mid_2", gv(2), 48);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    got.delete();
    run(40);
    chk("mid_after_count", got.size(), 0);
    chk("mid_after_valid", out_valid, 0);
    chk("mid_after_data", $signed(out_data), 0);
    chk("mid_after_busy", busy, 0);

    // Edge input: from -32760, 16'h8000 lands on -32767
    send(-32760);
    k = 0;
    while (busy && k < 9000) begin
      cyc();
      k++;
    end
    chk("edge_settle_busy", busy, 0);
    chk("edge_settle_data", $signed(out_data), -32760);
    got.delete();
    send(32'h0000_8000);
    run(20);
    chk("edge_count", got.size(), 1);
    chk("edge_0", gv(0), -32767);
    chk("edge_busy", busy, 0);
    got.delete();
    send(-32767);
    run(20);
    chk("same_target_count", got.size(), 0);

    // Randomised traffic against the model
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      in_valid = ($urandom_range(7) == 0);
      v = int'($urandom_range(99));
      if (v < 2)      in_data = 16'h8000;
      else if (v < 4) in_data = 16'h7FFF;
      else            in_data = 16'(int'($urandom_range(600)) - 300);
      out_rdy = ($urandom_range(3) != 0);
      rst     = ($urandom_range(399) == 0);
      cyc();
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    out_rdy  = 1'b1;
    run(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bc_ramp.md
BC_RAMP -- requirements
Module: bc_ramp

Interface
REQ-001 Parameter STEP, default 16: maximum magnitude change of the output command per tick (1..1024).
REQ-002 Parameter TICK_DIV, default 1000: number of CLK100MHZ cycles per ramp tick (>=2).
REQ-003 Parameter DWELL_TICKS, default 4: number of ticks held at zero on a direction reversal (>=1).
REQ-004 CLK100MHZ  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_data  in  16  signed two's-complement target speed/direction command from upstream.
REQ-007 in_valid  in  1  in_data is valid.
REQ-008 in_rdy  out  1  block accepts a target.
REQ-009 out_data  out  16  signed ramped command to the downstream PWM stage.
REQ-010 out_valid  out  1  out_data is valid.
REQ-011 out_rdy  in  1  downstream accepts out_data.
REQ-012 busy  out  1  high while the current command differs from the target or a dwell is in progress.

Function
REQ-013 A free-running tick counter shall count 0..TICK_DIV-1 and pulse tick for one cycle when its count is TICK_DIV-1.
REQ-014 in_rdy shall be 1 in every cycle except a reset cycle; on in_valid&in_rdy the target register shall load in_data, taking effect at the next tick.
REQ-015 in_data 16'h8000 shall be stored as -32767, so magnitudes are symmetric.
REQ-016 States: IDLE (cur==target), RAMP (stepping), DWELL (holding zero); the current command is cur.
REQ-017 Step goal: if cur!=0 and sign(target)!=sign(cur) with target!=0, the goal is 0; otherwise the goal is target.
REQ-018 On a tick in RAMP with no output pending, cur shall move toward the goal by STEP, or land exactly on the goal if |goal-cur|<=STEP; differences shall be computed at 17 bits with no overflow or overshoot.
REQ-019 Each change of cur shall be presented as out_data=cur with out_valid=1 in the cycle after the tick.
REQ-020 out_data and out_valid shall be held stable until out_valid&out_rdy; out_valid shall fall in the next cycle after transfer.
REQ-021 A tick occurring while out_valid is high and untransferred shall produce no step; the step is deferred to the next tick.
REQ-022 When cur reaches 0 on a reversal, the state shall go to DWELL; after DWELL_TICKS ticks it shall go to RAMP toward the target, or to IDLE if the target is 0.
REQ-023 A new target in RAMP that restores the sign of cur shall cancel the zero approach immediately (no dwell).
REQ-024 A new target during DWELL shall not shorten the dwell; the ramp after the dwell shall use the latest target.
REQ-025 In IDLE, a new target differing from cur shall enter RAMP; a target equal to cur shall produce no output.
REQ-026 If in_valid and tick coincide, the step shall use the old target.
REQ-027 busy shall be 1 in RAMP and DWELL and 0 in IDLE.

Reset
REQ-028 On rst: cur=0, target=0, out_data=0, out_valid=0, busy=0, tick counter=0, dwell counter=0, state IDLE; in_rdy=0 during the reset cycle.
REQ-029 rst asserted mid-ramp or mid-dwell shall abandon the operation without emitting any further output.

Configuration
REQ-030 Macro BC_RAMP_DWELL_EN defined: the reversal path through 0 with the DWELL state (REQ-017, REQ-022 to REQ-024) shall be active.
REQ-031 BC_RAMP_DWELL_EN undefined: no DWELL state; the goal is always target, and cur crosses zero in ordinary steps, with 0 emitted only if landed on exactly.

Verification (STEP=16, TICK_DIV=4, DWELL_TICKS=2, out_rdy=1 unless stated)
REQ-032 Reset: after rst, out_data=0, out_valid=0, busy=0, and in_rdy=1 in the first cycle after reset.
REQ-033 Ramp up: target 40 from 0 -> outputs 16, 32, 40 on three consecutive ticks, then IDLE with busy=0.
REQ-034 Reversal (macro defined): cur=40, target -20 -> outputs 24, 8, 0, then two silent dwell ticks, then -16, -20; without the macro -> 24, 8, -8, -20.
REQ-035 Backpressure: target 40 with out_rdy=0 for 10 ticks -> out_data held at 16 with out_valid high; after out_rdy=1, 32 is emitted at the next tick.
REQ-036 Reset mid-ramp: target 1000, rst after the third output (48) -> outputs return to reset values and no further outputs occur while the target remains 0.
REQ-037 Edge input: in_data 16'h8000 from cur=-32760 -> a single output of -32767, then IDLE.
